// File: rtl/ring_arbiter.sv
`default_nettype none
// ============================================================================
// ring_arbiter : round-robin arbiter, one-hot rotating pointer, quantum preempt
// Revision     : 1.0
// ============================================================================
module ring_arbiter #(
  parameter int N       = 6,
  parameter int QUANTUM = 8,
  localparam int IDW    = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  output logic [N-1:0]   ptr,
  output logic           preempt
);

  localparam int            CW   = $clog2(QUANTUM);
  localparam logic [CW-1:0] QMAX = CW'(QUANTUM - 1);
  localparam logic [IDW:0]  NW   = (IDW + 1)'(N);

  typedef enum logic [0:0] {IDLE = 1'b0, OWNED = 1'b1} state_t;

  state_t         r_state;
  logic [N-1:0]   r_grant;
  logic [N-1:0]   r_ptr;
  logic           r_valid;
  logic [IDW-1:0] r_id;
  logic           r_preempt;
  logic [CW-1:0]  r_cnt;

  logic [IDW-1:0] w_ptr_idx;
  logic [IDW-1:0] w_win;
  logic [IDW:0]   w_sum;
  logic [N-1:0]   w_win_oh;
  logic [N-1:0]   w_next_ptr;
  logic           w_own_req;
  logic           w_others;
  logic           w_expire;
  logic           w_release;
  logic           w_issue;

  // Scan downward in priority order so the last hit is the highest-priority one.
  always_comb begin
    w_ptr_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (r_ptr[i]) w_ptr_idx = IDW'(i);
    end
    w_win = '0;
    w_sum = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, w_ptr_idx} + (IDW + 1)'(k);
      if (w_sum >= NW) w_sum = w_sum - NW;
      if (req[w_sum[IDW-1:0]]) w_win = w_sum[IDW-1:0];
    end
  end

  always_comb begin
    w_win_oh   = N'(1) << w_win;
    w_next_ptr = {w_win_oh[N-2:0], w_win_oh[N-1]};
    w_own_req  = |(req & r_grant);
    w_others   = |(req & ~r_grant);
    w_expire   = (r_state == OWNED) && w_own_req && w_others && (r_cnt == QMAX);
    w_release  = (r_state == OWNED) && !w_own_req && !w_others;
    w_issue    = ((r_state == IDLE) && (|req))
              || ((r_state == OWNED) && !w_own_req && w_others)
              || w_expire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_valid   <= 1'b0;
      r_id      <= '0;
      r_ptr     <= N'(1);
      r_preempt <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_preempt <= w_expire;
      if (w_issue) begin
        r_state <= OWNED;
        r_grant <= w_win_oh;
        r_valid <= 1'b1;
        r_id    <= w_win;
        r_ptr   <= w_next_ptr;
        r_cnt   <= '0;
      end else if (w_release) begin
        r_state <= IDLE;
        r_grant <= '0;
        r_valid <= 1'b0;
        r_id    <= '0;
      end else if ((r_state == OWNED) && (r_cnt != QMAX)) begin
        // Saturates: an uncontended owner keeps the grant indefinitely.
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_valid;
  assign grant_id    = r_id;
  assign ptr         = r_ptr;
  assign preempt     = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_ring_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ring_arbiter : scoreboard bench for ring_arbiter (N=6, QUANTUM=8)
// Revision        : 1.0
// ============================================================================
module tb_ring_arbiter;

  localparam int N   = 6;
  localparam int Q   = 8;
  localparam int IDW = 3;

  typedef struct packed {
    logic [N-1:0]   grant;
    logic           valid;
    logic [IDW-1:0] id;
    logic [N-1:0]   ptr;
    logic           pre;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic [N-1:0]   ptr;
  logic           preempt;

  ring_arbiter #(.N(N), .QUANTUM(Q)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .ptr         (ptr),
    .preempt     (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb_q[$];

  // Reference model state (index based, updated when stimulus is driven)
  int m_owned = 0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;
  int m_pre   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic [N-1:0] rq);
    int   win;
    bit   give;
    bit   others;
    exp_t e;
    win  = 0;
    give = 0;
    if (r) begin
      m_owned = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_pre = 0;
    end else begin
      m_pre = 0;
      for (int k = N - 1; k >= 0; k--) begin
        if (rq[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      others = 0;
      for (int i = 0; i < N; i++) begin
        if (rq[i] && !(m_owned != 0 && i == m_owner)) others = 1;
      end
      if (m_owned == 0) begin
        give = (rq != '0);
      end else if (!rq[m_owner]) begin
        if (others) give = 1;
        else m_owned = 0;
      end else if (others && m_cnt == Q - 1) begin
        give  = 1;
        m_pre = 1;
      end else if (m_cnt < Q - 1) begin
        m_cnt++;
      end
      if (give) begin
        m_owned = 1;
        m_owner = win;
        m_ptr   = (win + 1) % N;
        m_cnt   = 0;
      end
    end
    e.grant = (m_owned != 0) ? N'(1) << m_owner : '0;
    e.valid = (m_owned != 0);
    e.id    = (m_owned != 0) ? IDW'(m_owner) : '0;
    e.ptr   = N'(1) << m_ptr;
    e.pre   = (m_pre != 0);
    sb_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic [N-1:0] rq);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    model(r, rq);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk("sb_grant", grant, e.grant);
      chk("sb_valid", grant_valid, e.valid);
      chk("sb_id", grant_id, e.id);
      chk("sb_ptr", ptr, e.ptr);
      chk("sb_preempt", preempt, e.pre);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;

    // Reset then single request
    step(1'b1, '0);
    step(1'b1, '0);
    chk("rst_grant", grant, 6'b000000);
    chk("rst_ptr", ptr, 6'b000001);
    chk("rst_preempt", preempt, 1'b0);
    step(1'b0, 6'b000001);
    chk("single_grant", grant, 6'b000001);
    chk("single_id", grant_id, 3'd0);
    chk("single_ptr", ptr, 6'b000010);
    step(1'b0, 6'b000000);
    chk("idle_grant", grant, 6'b000000);
    chk("idle_ptr", ptr, 6'b000010);

    // Release with direct handoff
    step(1'b1, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 6'b000101);
    chk("hold_grant", grant, 6'b000001);
    step(1'b0, 6'b000100);
    chk("handoff_grant", grant, 6'b000100);
    chk("handoff_ptr", ptr, 6'b001000);
    chk("handoff_preempt", preempt, 1'b0);
    step(1'b0, 6'b000000);

    // Quantum rotation between two contenders
    step(1'b1, '0);
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 6'b000011);
      chk("rot_grant", grant, (((i - 1) / Q) % 2 == 1) ? 6'b000010 : 6'b000001);
      chk("rot_preempt", preempt, (i > 1 && (i - 1) % Q == 0) ? 1'b1 : 1'b0);
    end

    // Wrap-around of the pointer
    step(1'b1, '0);
    step(1'b0, 6'b010000);
    chk("wrap_setup_ptr", ptr, 6'b100000);
    step(1'b0, 6'b100001);
    chk("wrap_grant", grant, 6'b100000);
    chk("wrap_ptr", ptr, 6'b000001);
    step(1'b0, 6'b000001);
    chk("wrap_release_grant", grant, 6'b000001);

    // Solo owner saturates, then gets preempted immediately
    step(1'b1, '0);
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 6'b001000);
      chk("solo_grant", grant, 6'b001000);
      chk("solo_preempt", preempt, 1'b0);
    end
    step(1'b0, 6'b001010);
    chk("sat_grant", grant, 6'b000010);
    chk("sat_preempt", preempt, 1'b1);
    step(1'b0, 6'b001010);
    chk("sat_pulse_end", preempt, 1'b0);

    // Reset in the middle of a grant
    step(1'b1, '0);
    step(1'b0, 6'b000100);
    step(1'b0, 6'b000100);
    chk("mid_pre_grant", grant, 6'b000100);
    step(1'b1, 6'b000100);
    chk("mid_rst_grant", grant, 6'b000000);
    chk("mid_rst_ptr", ptr, 6'b000001);
    chk("mid_rst_preempt", preempt, 1'b0);
    step(1'b0, 6'b000100);
    chk("mid_regrant", grant, 6'b000100);

    // Random traffic with sticky requests and occasional reset
    begin
      logic [N-1:0] rq;
      rq = '0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 3) == 0) rq = N'($urandom);
        step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0, rq);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
